// File: rtl/rrv_mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package rrv_mem_port_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_LS = 2'd1,
    ST_BUSY_IF = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  // Which requester won arbitration in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LS   = 2'd1,
    GNT_IF   = 2'd2
  } gnt_src_e;

  // addi x0, x0, 0 -- handed to fetch when its transaction is aborted.
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Width of the memory wait counter.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/rrv_mem_port_arbiter_wait_timer.sv
// Wait-cycle counter for an outstanding memory transaction; flags expiry.
module rrv_wait_timer
  import rrv_mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = WAIT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == CNT_W'(MAX_WAIT));

  // Next count: clear wins, otherwise count up and hold once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rrv_mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store unit.
// LS has priority; IF is forced through after STARVE_LIM consecutive LS grants
// while it waits. Each transaction is IDLE -> BUSY_x -> RESP -> IDLE.
module rrv_mem_port_arbiter
  import rrv_mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_LIM = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic                    stall_if,
  output logic                    stall_mem,
  output logic                    timeout_err
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int SW   = $clog2(STARVE_LIM + 1);

  arb_state_e state_q, state_d;
  gnt_src_e   gnt;
  logic       tmr_clr, tmr_en, tmr_expired;
  logic       done_ack, done_to;
  logic       starve_full;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  mem_req_q, mem_we_q;
  logic [BE_W-1:0]       mem_be_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, ls_rdata_q;
  logic                  if_valid_q, ls_valid_q, timeout_err_q;

  // Saturating increment of the IF starvation counter.
  function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIM)) ? v : v + 1'b1;
  endfunction

  // Read data returned to a requester: memory data, or the abort value.
  function automatic logic [DATA_WIDTH-1:0] resp_data(input logic ack,
                                                      input logic [DATA_WIDTH-1:0] rd,
                                                      input logic [DATA_WIDTH-1:0] abort_val);
    return ack ? rd : abort_val;
  endfunction

  assign starve_full = (starve_q == SW'(STARVE_LIM));

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign if_valid    = if_valid_q;
  assign ls_valid    = ls_valid_q;
  assign timeout_err = timeout_err_q;

  // Stalls are gated by reset so the pipeline sees no stall while held in reset.
  assign stall_if  = rst_n & if_req & ~if_valid_q;
  assign stall_mem = rst_n & ls_req & ~ls_valid_q;

  rrv_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (WAIT_CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, completion detection and next state.
  always_comb begin
    state_d  = state_q;
    gnt      = GNT_NONE;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ls_req && !(if_req && starve_full)) begin
          gnt     = GNT_LS;
          state_d = ST_BUSY_LS;
          tmr_clr = 1'b1;
        end else if (if_req) begin
          gnt     = GNT_IF;
          state_d = ST_BUSY_IF;
          tmr_clr = 1'b1;
        end
      end
      ST_BUSY_LS, ST_BUSY_IF: begin
        tmr_en = 1'b1;
        // An ack in the expiry cycle still completes normally.
        if (mem_ack) begin
          done_ack = 1'b1;
          state_d  = ST_RESP;
        end else if (tmr_expired) begin
          done_to = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation count: LS grants while IF waits; cleared on IF grant or idle IF.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE) begin
      if (gnt == GNT_IF || !if_req) begin
        starve_d = '0;
      end else if (gnt == GNT_LS) begin
        starve_d = starve_inc(starve_q);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Memory port: load the granted request, hold it, release on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (gnt)
        GNT_LS: begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= ls_we;
          mem_be_q    <= ls_be;
          mem_addr_q  <= ls_addr;
          mem_wdata_q <= ls_wdata;
        end
        GNT_IF: begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b0;
          mem_be_q    <= '1;
          mem_addr_q  <= if_addr;
          mem_wdata_q <= '0;
        end
        default: begin
          if (done_ack || done_to) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Response: capture data on completion and raise a one-cycle valid in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q    <= '0;
      ls_rdata_q    <= '0;
      if_valid_q    <= 1'b0;
      ls_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if_valid_q    <= 1'b0;
      ls_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      if (done_ack || done_to) begin
        timeout_err_q <= done_to;
        if (state_q == ST_BUSY_IF) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= resp_data(done_ack, mem_rdata, DATA_WIDTH'(RV32_NOP));
        end else begin
          ls_valid_q <= 1'b1;
          ls_rdata_q <= resp_data(done_ack, mem_rdata, '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_rrv_mem_port_arbiter.sv
// Bench for rrv_mem_port_arbiter: directed vector table, hand-written corner
// sequences and a randomized two-requester run against a transaction-level model.
module tb_rrv_mem_port_arbiter;

  localparam int NEVER = 1000;
  localparam int LIM   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] ls_rdata;
  logic        ls_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;

  rrv_mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Memory behind the port (written from mem_* signals) and the model's view
  // (written from the requester's side).
  logic [31:0] rmem [0:511];
  logic [31:0] mmem [0:511];

  function automatic int idx(input logic [31:0] a);
    return int'({a[12], a[9:2]});
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return (v * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // Memory responder: ack arrives cur_dly cycles after mem_req rises.
  int ack_dly  = 1;
  bit rand_dly = 1'b0;
  int cur_dly  = 0;
  int wcnt     = 0;

  initial begin
    for (int i = 0; i < 512; i++) rmem[i] = pat(i);
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_req) begin
        if (wcnt == 0) cur_dly = rand_dly ? (($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 4))) : ack_dly;
        wcnt++;
        if (wcnt > cur_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rmem[idx(mem_addr)];
          if (mem_we) rmem[idx(mem_addr)] = merge(rmem[idx(mem_addr)], mem_wdata, mem_be);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Port monitor: arbitration order model, request stability, valid exclusivity.
  bit          mon_on = 1'b0;
  int          streak = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [4:0]  prev_ctl;

  initial begin
    bit exp_ls;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) streak = 0;
      if (mon_on && mem_req && !prev_req) begin
        exp_ls = ls_req && !(if_req && streak == LIM);
        check("arb_winner_is_ls", 32'(mem_addr[12]), 32'(exp_ls));
        if (!exp_ls) streak = 0;
        else if (if_req && streak < LIM) streak++;
      end
      if (mem_req && prev_req) begin
        check("mem_addr_hold", mem_addr, prev_addr);
        check("mem_wdata_hold", mem_wdata, prev_wdata);
        check("mem_ctl_hold", 32'({mem_we, mem_be}), 32'(prev_ctl));
      end
      if (if_valid && ls_valid) fail_bound("both_valid_exclusive");
      prev_req   = mem_req;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_ctl   = {mem_we, mem_be};
    end
  end

  // Directed single-transaction vectors.
  typedef struct {
    bit          is_ls;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] preload;
    int          dly;
    logic [31:0] exp_rdata;
    bit          exp_to;
    int          exp_lat;
    logic [31:0] exp_mem;
  } row_t;

  row_t rows [8];

  task automatic run_row(input row_t r, input string tag);
    int lat;
    bit got, seen;
    rmem[idx(r.addr)] = r.preload;
    ack_dly = r.dly;
    @(negedge clk);
    if (r.is_ls) begin
      ls_req = 1'b1; ls_we = r.we; ls_be = r.be; ls_addr = r.addr; ls_wdata = r.wdata;
    end else begin
      if_req = 1'b1; if_addr = r.addr;
    end
    #1;
    check({tag, "_stall_on"}, 32'(r.is_ls ? stall_mem : stall_if), 32'd1);
    lat = 0; got = 1'b0; seen = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_req && !seen) begin
        seen = 1'b1;
        check({tag, "_mem_addr"}, mem_addr, r.addr);
        check({tag, "_mem_we"}, 32'(mem_we), 32'(r.we));
        if (r.is_ls) check({tag, "_mem_be"}, 32'(mem_be), 32'(r.be));
      end
      if (mem_req && r.we) check({tag, "_mem_wdata"}, mem_wdata, r.wdata);
      got = r.is_ls ? ls_valid : if_valid;
    end
    if (!got) begin
      fail_bound({tag, "_valid"});
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(r.exp_lat));
      check({tag, "_timeout_err"}, 32'(timeout_err), 32'(r.exp_to));
      check({tag, "_other_valid"}, 32'(r.is_ls ? if_valid : ls_valid), 32'd0);
      check({tag, "_stall_off"}, 32'(r.is_ls ? stall_mem : stall_if), 32'd0);
      check({tag, "_mem_req_off"}, 32'(mem_req), 32'd0);
      if (!r.we) check({tag, "_rdata"}, r.is_ls ? ls_rdata : if_rdata, r.exp_rdata);
      else       check({tag, "_stored"}, rmem[idx(r.addr)], r.exp_mem);
    end
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
  endtask

  // Randomized fetch requester.
  task automatic if_proc(input int n);
    logic [31:0] a, exp;
    bit got, to;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 32'($urandom_range(0, 63)) << 2;
      if_addr = a;
      if_req  = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(posedge clk);
        #1;
        if (if_valid) got = 1'b1;
        else check("rnd_stall_if", 32'(stall_if), 32'd1);
      end
      if (!got) begin
        fail_bound("rnd_if_valid");
      end else begin
        to  = (cur_dly > 15);
        exp = to ? 32'h0000_0013 : mmem[idx(a)];
        check("rnd_if_rdata", if_rdata, exp);
        check("rnd_if_timeout", 32'(timeout_err), 32'(to));
        check("rnd_stall_if_off", 32'(stall_if), 32'd0);
      end
      @(negedge clk);
      if_req = 1'b0;
    end
  endtask

  // Randomized load/store requester.
  task automatic ls_proc(input int n);
    logic [31:0] a, wd;
    logic [3:0]  be;
    bit          we, got, to;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(1, 15));
      wd = $urandom;
      ls_addr = a; ls_we = we; ls_be = be; ls_wdata = wd;
      ls_req  = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(posedge clk);
        #1;
        if (ls_valid) got = 1'b1;
        else check("rnd_stall_mem", 32'(stall_mem), 32'd1);
      end
      if (!got) begin
        fail_bound("rnd_ls_valid");
      end else begin
        to = (cur_dly > 15);
        check("rnd_ls_timeout", 32'(timeout_err), 32'(to));
        if (!we) check("rnd_ls_rdata", ls_rdata, to ? 32'h0 : mmem[idx(a)]);
        else if (!to) mmem[idx(a)] = merge(mmem[idx(a)], wd, be);
      end
      @(negedge clk);
      ls_req = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string order;
    int n, ls_t, if_t, cnt;

    rows[0] = '{0, 0, 4'hF, 32'h0000_0100, 32'h0, 32'h0050_0093, 1, 32'h0050_0093, 0, 3, 32'h0};
    rows[1] = '{1, 0, 4'hF, 32'h0000_2000, 32'h0, 32'h1122_3344, 1, 32'h1122_3344, 0, 3, 32'h0};
    rows[2] = '{1, 1, 4'b0011, 32'h0000_2004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3, 32'h0, 0, 5, 32'hFFFF_BEEF};
    rows[3] = '{0, 0, 4'hF, 32'h0000_0180, 32'h0, 32'h1234_5678, NEVER, 32'h0000_0013, 1, 17, 32'h0};
    rows[4] = '{1, 0, 4'hF, 32'h0000_2008, 32'h0, 32'hCAFE_F00D, NEVER, 32'h0, 1, 17, 32'h0};
    rows[5] = '{0, 0, 4'hF, 32'h0000_0104, 32'h0, 32'h00A0_0113, 15, 32'h00A0_0113, 0, 17, 32'h0};
    rows[6] = '{1, 0, 4'hF, 32'h0000_200C, 32'h0, 32'h89AB_CDEF, 2, 32'h89AB_CDEF, 0, 4, 32'h0};
    rows[7] = '{1, 1, 4'b1100, 32'h0000_2010, 32'h0123_4567, 32'h0, 1, 32'h0, 0, 3, 32'h0123_0000};

    // Reset state, with a fetch request already pending.
    #2 rst_n = 1'b0;
    if_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_ls_valid", 32'(ls_valid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_stall_if", 32'(stall_if), 32'd0);
    check("rst_stall_mem", 32'(stall_mem), 32'd0);
    @(negedge clk);
    if_req = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_row(rows[i], $sformatf("row%0d", i));

    // Simultaneous fetch and load: LS first, one idle cycle, then IF.
    rmem[idx(32'h100)]  = 32'h0050_0093;
    rmem[idx(32'h2000)] = 32'h55AA_55AA;
    ack_dly = 1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h2000;
    n = 0; ls_t = 0; if_t = 0;
    while ((ls_t == 0 || if_t == 0) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (ls_valid) begin
        ls_t = n;
        check("both_ls_rdata", ls_rdata, 32'h55AA_55AA);
        @(negedge clk);
        ls_req = 1'b0;
      end else if (if_valid) begin
        if_t = n;
        check("both_if_rdata", if_rdata, 32'h0050_0093);
        @(negedge clk);
        if_req = 1'b0;
      end
    end
    check("both_ls_cycle", 32'(ls_t), 32'd3);
    check("both_if_cycle", 32'(if_t), 32'd7);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);

    // Starvation: IF held while LS re-requests back-to-back.
    ack_dly = 1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h2000;
    order = ""; cnt = 0; n = 0;
    while (cnt < 6 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (ls_valid) begin
        order = {order, "L"};
        cnt++;
        if (cnt == 6) begin
          @(negedge clk);
          ls_req = 1'b0;
        end
      end else if (if_valid) begin
        order = {order, "I"};
        cnt++;
        @(negedge clk);
        if_req = 1'b0;
      end
    end
    if (cnt < 6) fail_bound("starve_sequence");
    else check("starve_order", 32'(order == "LLLLIL"), 32'd1);
    if (order != "LLLLIL") $display("  grant order seen: %s", order);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);

    // Reset while BUSY_LS with a fetch waiting.
    ack_dly = NEVER;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h2000;
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    check("prerst_mem_req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_stall_mem", 32'(stall_mem), 32'd0);
    check("midrst_stall_if", 32'(stall_if), 32'd0);
    check("midrst_ls_valid", 32'(ls_valid), 32'd0);
    check("midrst_if_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    ls_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_dly = 1;
    run_row(rows[0], "post_rst");

    // Randomized mixed traffic.
    for (int i = 0; i < 512; i++) begin
      rmem[i] = pat(i);
      mmem[i] = pat(i);
    end
    rand_dly = 1'b1;
    streak   = 0;
    mon_on   = 1'b1;
    fork
      if_proc(40);
      ls_proc(60);
    join
    mon_on = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
